// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and defaults.
package seq_div_pkg;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Error-case results; quotient saturates to all ones, width supplied by the caller.
  function automatic logic [63:0] err_quot(input int dw);
    return (64'd1 << dw) - 64'd1;
  endfunction
endpackage

// File: rtl/seq_div_if.sv
// Start/busy/done handshake bundle between a requester and the divider.
interface seq_div_if #(parameter int DW = 16);
  logic            start;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            busy;
  logic            done;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module seq_div_step #(parameter int DW = 16) (
  input  logic [DW-1:0] r,
  input  logic          nbit,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);
  logic [DW:0] shifted;

  // Partial remainder is always < divisor, so the difference fits back into DW bits.
  always_comb begin
    shifted = {r, nbit};
    q_bit   = (shifted >= {1'b0, divisor});
    r_next  = q_bit ? (shifted[DW-1:0] - divisor) : shifted[DW-1:0];
  end
endmodule

// File: rtl/seq_div_top.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
module seq_div_top
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);
  localparam int            CW   = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state;
  logic [CW-1:0] step;
  logic [DW-1:0] rem_r, shf_r, dsr_r;
  logic [DW-1:0] rem_nx;
  logic          q_bit;
  logic [DW-1:0] div_hi, div_lo;

  assign div_hi = bus.dividend[2*DW-1:DW];
  assign div_lo = bus.dividend[DW-1:0];

  seq_div_step #(.DW(DW)) u_step (
    .r       (rem_r),
    .nbit    (shf_r[DW-1]),
    .divisor (dsr_r),
    .r_next  (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      step            <= '0;
      rem_r           <= '0;
      shf_r           <= '0;
      dsr_r           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            step            <= '0;
            dsr_r           <= bus.divisor;
            rem_r           <= div_hi;
            shf_r           <= div_lo;
            if (bus.divisor == '0) begin
              state           <= S_DONE;
              bus.done        <= 1'b1;
              bus.div_by_zero <= 1'b1;
              bus.quotient    <= DW'(err_quot(DW));
              bus.remainder   <= div_lo;
            end else if (div_hi >= bus.divisor) begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.overflow  <= 1'b1;
              bus.quotient  <= DW'(err_quot(DW));
              bus.remainder <= '0;
            end else begin
              state    <= S_BUSY;
              bus.busy <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // Quotient bits fill the low half from the right as dividend bits leave on the left.
          rem_r <= rem_nx;
          shf_r <= {shf_r[DW-2:0], q_bit};
          step  <= step + CW'(1);
          if (step == LAST) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= {shf_r[DW-2:0], q_bit};
            bus.remainder <= rem_nx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_top.sv
// Randomized scoreboard bench for seq_div_top against a plain-arithmetic division model.
module tb_seq_div_top;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_div_if #(.DW(DW)) bus ();
  seq_div_top #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            cyc;
    string         tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: integer division; overflow whenever the true quotient needs more than DW bits.
  function automatic exp_t model(input logic [2*DW-1:0] a, input logic [DW-1:0] b, input string tag);
    exp_t e;
    logic [2*DW-1:0] qq, rr;
    e.tag = tag; e.dbz = 1'b0; e.ovf = 1'b0; e.cyc = 0;
    if (b == '0) begin
      e.dbz = 1'b1; e.q = '1; e.r = a[DW-1:0];
    end else begin
      qq = a / {{DW{1'b0}}, b};
      rr = a % {{DW{1'b0}}, b};
      if (qq[2*DW-1:DW] != '0) begin
        e.ovf = 1'b1; e.q = '1; e.r = '0;
      end else begin
        e.q = qq[DW-1:0]; e.r = rr[DW-1:0];
      end
    end
    return e;
  endfunction

  // Called at a negedge; drives start at the first negedge the divider is not busy.
  task automatic issue(input logic [2*DW-1:0] a, input logic [DW-1:0] b, input string tag);
    int   guard = 0;
    exp_t e;
    while (bus.busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) fail_now({tag, ".wait_idle"});
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    e     = model(a, b, tag);
    e.cyc = cyc + 1 + ((e.dbz || e.ovf) ? 0 : DW);
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (sbq.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() != 0) begin
      fail_now({tag, ".drain"});
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.tag, ".quot"}, 64'(bus.quotient),    64'(e.q));
          chk({e.tag, ".rem"},  64'(bus.remainder),   64'(e.r));
          chk({e.tag, ".dbz"},  64'(bus.div_by_zero), 64'(e.dbz));
          chk({e.tag, ".ovf"},  64'(bus.overflow),    64'(e.ovf));
          chk({e.tag, ".cyc"},  64'(cyc),             64'(e.cyc));
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, 64'(bus.busy),        64'd0);
    chk({tag, ".done"}, 64'(bus.done),        64'd0);
    chk({tag, ".quot"}, 64'(bus.quotient),    64'd0);
    chk({tag, ".rem"},  64'(bus.remainder),   64'd0);
    chk({tag, ".dbz"},  64'(bus.div_by_zero), 64'd0);
    chk({tag, ".ovf"},  64'(bus.overflow),    64'd0);
  endtask

  initial begin
    logic [DW-1:0] b, hi, lo;
    int mode;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, then a start pulse during BUSY which must be ignored.
    issue(32'd100, 16'd7, "t1_basic");
    repeat (4) @(negedge clk);
    chk("t5_poke_in_busy", 64'(bus.busy), 64'd1);
    bus.dividend = 32'h0000_0009; bus.divisor = 16'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    issue(32'h0000_FFFF, 16'd1, "t2_max_q");
    issue(32'h1234_5678, 16'd0, "t3_dbz");
    issue(32'h0001_0000, 16'd1, "t4_ovf");
    issue(32'h7FFE_0001, 16'hFFFF, "t_bigdiv");
    issue(32'h0000_0000, 16'd3, "t_zero_num");
    drain("directed");

    // Reset in the middle of an operation: outputs clear and no done follows.
    @(negedge clk);
    bus.dividend = 32'h0000_1234; bus.divisor = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("t6_mid_rst");
    rst = 1'b0;
    repeat (DW + 4) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 9));
      b  = DW'($urandom_range(1, (1 << DW) - 1));
      lo = DW'($urandom);
      if (mode == 0) begin
        b  = '0;
        hi = DW'($urandom);
      end else if (mode == 1) begin
        hi = DW'($urandom);
      end else begin
        hi = DW'($urandom % b);
      end
      issue({hi, lo}, b, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain("random");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
